// File: rtl/memory_arbiter.sv
// Two-port arbiter in front of a single-port block RAM. Each grant performs
// one read or write. Address, data and write enable are held for a fixed settle window.
module memory_arbiter #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 7
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    // state  | meaning
    // IDLE   | no owner; arbitrate and capture the winner's request
    // ACCESS | first cycle driving the RAM with the captured request
    // WAIT   | RAM settle window of WAIT_CYCLES cycles
    // DONE   | one-cycle completion pulse; read data already captured
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       sel;
    logic       last_grant;
    logic       we_lat;
    logic       pick1;

    // Port 1 wins when it is alone, or when both ask and port 0 was served last.
    assign pick1 = req1 && (!req0 || !last_grant);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (req0 || req1) state_nxt = S_ACCESS;
            S_ACCESS: state_nxt = S_WAIT;
            S_WAIT:   if (cnt == CNT_LAST) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            sel        <= 1'b0;
            last_grant <= 1'b1;
            we_lat     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    cnt <= 4'd0;
                    if (req0 || req1) begin
                        sel        <= pick1;
                        last_grant <= pick1;
                        mem_addr   <= pick1 ? addr1  : addr0;
                        mem_wdata  <= pick1 ? wdata1 : wdata0;
                        we_lat     <= pick1 ? we1    : we0;
                    end
                end
                S_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= 4'd0;
                        if (!we_lat) rdata <= mem_rdata;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: cnt <= 4'd0;
            endcase
        end
    end

    // Outputs decode from the state register so reset clears them immediately.
    assign busy     = (state != S_IDLE);
    assign mem_wren = we_lat && ((state == S_ACCESS) || (state == S_WAIT));
    assign gnt0     = busy && !sel;
    assign gnt1     = busy && sel;
    assign done0    = (state == S_DONE) && !sel;
    assign done1    = (state == S_DONE) && sel;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: behavioural RAM, reference memory and a
// scoreboard of expected (port, rdata) pairs popped on each done pulse.
module tb_memory_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int WC = 7;

    logic          clock;
    logic          resetn;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wren;
    logic          gnt0, gnt1, done0, done1, busy;
    logic [DW-1:0] rdata;

    memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
        .clock(clock), .resetn(resetn),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wren(mem_wren), .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1), .rdata(rdata), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [DW-1:0] ram     [32];
    logic [DW-1:0] ref_mem [32];
    always @(posedge clock) if (mem_wren) ram[mem_addr] <= mem_wdata;
    assign mem_rdata = ram[mem_addr];

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          wren_cnt = 0;
    int          done_cnt = 0;
    logic        prev_done = 1'b0;
    logic [31:0] exp_rdata = '0;

    always @(negedge clock) begin
        exp_t e;
        if (busy) begin
            n_checks++;
            if (gnt0 && gnt1) begin
                n_fail++;
                $display("FAIL gnt_excl: gnt0=%b gnt1=%b, required not both", gnt0, gnt1);
            end
        end
        if (done0 || done1) begin
            n_checks++;
            if (done0 && done1) begin
                n_fail++;
                $display("FAIL done_excl: done0=%b done1=%b", done0, done1);
            end
            n_checks++;
            if (prev_done) begin
                n_fail++;
                $display("FAIL done_width: done high on consecutive cycles");
            end
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected: done0=%b done1=%b with empty scoreboard", done0, done1);
            end else begin
                e = sb.pop_front();
                if ((done1 ? 1 : 0) !== e.port) begin
                    n_fail++;
                    $display("FAIL done_port: got port %0d, required %0d", done1 ? 1 : 0, e.port);
                end
                n_checks++;
                if (rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL rdata: got %h, required %h", rdata, e.data);
                end
            end
            done_cnt++;
        end
        prev_done = done0 | done1;
        if (mem_wren) wren_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ram[a]     = d;
        ref_mem[a] = d;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn    = 1'b1;
        exp_rdata = '0;
        tick();
    endtask

    // One access on one port; pulse=1 drops req after the first cycle.
    // chg_k>0 retargets the port address that many cycles after the grant.
    task automatic run_access(input int port, input logic we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input bit pulse,
                              input int chg_k, input logic [AW-1:0] chg_a);
        exp_t e;
        int   lat;
        if (we) ref_mem[a] = d;
        else    exp_rdata  = ref_mem[a];
        e.port = port;
        e.data = exp_rdata;
        sb.push_back(e);
        if (port == 0) begin we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1; end
        else           begin we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1; end
        wren_cnt = 0;
        lat      = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) begin
                n_checks++;
                if ((port == 0 ? gnt0 : gnt1) !== 1'b1) begin
                    n_fail++;
                    $display("FAIL grant_n1: port %0d gnt0=%b gnt1=%b, required own grant", port, gnt0, gnt1);
                end
                if (pulse) begin req0 = 1'b0; req1 = 1'b0; end
            end
            if (chg_k > 0 && k == chg_k) begin
                if (port == 0) addr0 = chg_a;
                else           addr1 = chg_a;
            end
            if (busy) begin
                n_checks++;
                if (mem_addr !== a) begin
                    n_fail++;
                    $display("FAIL mem_addr_hold: cycle %0d got %0d, required %0d", k, mem_addr, a);
                end
            end
            if ((port == 0 && done0) || (port == 1 && done1)) begin
                lat = k;
                break;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        n_checks++;
        if (lat != WC + 2) begin
            n_fail++;
            $display("FAIL done_latency: port %0d got %0d cycles, required %0d", port, lat, WC + 2);
        end
        tick();
        n_checks++;
        if (wren_cnt != (we ? WC + 1 : 0)) begin
            n_fail++;
            $display("FAIL wren_cycles: got %0d, required %0d", wren_cnt, we ? WC + 1 : 0);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_done: busy=%b, required 0", busy);
        end
    endtask

    // Both ports request reads continuously; grants must alternate starting at port 0.
    task automatic run_both(input int n_done);
        exp_t e;
        int   seen;
        int   last_cnt;
        we0 = 1'b0; addr0 = 5'd7;
        we1 = 1'b0; addr1 = 5'd8;
        for (int i = 0; i < n_done; i++) begin
            exp_rdata = ref_mem[(i % 2 == 0) ? 7 : 8];
            e.port    = i % 2;
            e.data    = exp_rdata;
            sb.push_back(e);
        end
        req0 = 1'b1;
        req1 = 1'b1;
        seen     = 0;
        last_cnt = done_cnt;
        for (int k = 0; k < 30 * n_done && seen < n_done; k++) begin
            tick();
            if (done0 || done1) begin
                n_checks++;
                if ((done1 ? 1 : 0) !== seen % 2) begin
                    n_fail++;
                    $display("FAIL rr_order: done %0d from port %0d, required %0d", seen, done1 ? 1 : 0, seen % 2);
                end
                seen++;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (done_cnt - last_cnt != n_done) begin
            n_fail++;
            $display("FAIL rr_count: got %0d dones, required %0d", done_cnt - last_cnt, n_done);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #3;
        n_checks++;
        if ({mem_addr, mem_wdata, mem_wren, gnt0, gnt1, done0, done1, rdata, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: addr=%h wdata=%h wren=%b gnt=%b%b done=%b%b rdata=%h busy=%b, required all 0",
                     mem_addr, mem_wdata, mem_wren, gnt0, gnt1, done0, done1, rdata, busy);
        end
        do_reset();
    endtask

    task automatic test_read_p0();
        preload(5'd5, 32'hDEADBEEF);
        run_access(0, 1'b0, 5'd5, '0, 1'b0, 0, '0);
    endtask

    task automatic test_write_p1();
        run_access(1, 1'b1, 5'd3, 32'h12345678, 1'b0, 0, '0);
        run_access(0, 1'b0, 5'd3, '0, 1'b0, 0, '0);
    endtask

    task automatic test_addr_hold();
        preload(5'd9, 32'h99999999);
        run_access(0, 1'b0, 5'd5, '0, 1'b0, 2, 5'd9);
    endtask

    task automatic test_req_pulse();
        preload(5'd12, 32'hC0FFEE12);
        run_access(1, 1'b0, 5'd12, '0, 1'b1, 0, '0);
    endtask

    task automatic test_round_robin();
        preload(5'd7, 32'h77770007);
        preload(5'd8, 32'h88880008);
        resetn = 1'b0;
        #2;
        do_reset();
        run_both(4);
    endtask

    task automatic test_reset_mid_wait();
        int dc;
        we1 = 1'b1; addr1 = 5'd10; wdata1 = 32'hAAAA5555; req1 = 1'b1;
        ref_mem[10] = 32'hAAAA5555;
        repeat (4) tick();
        n_checks++;
        if (mem_wren !== 1'b1) begin
            n_fail++;
            $display("FAIL wren_in_wait: got %b, required 1", mem_wren);
        end
        dc = done_cnt;
        #2;
        resetn = 1'b0;
        req1   = 1'b0;
        #1;
        n_checks++;
        if ({mem_wren, gnt0, gnt1, busy} !== 4'b0) begin
            n_fail++;
            $display("FAIL async_abort: wren=%b gnt0=%b gnt1=%b busy=%b, required all 0", mem_wren, gnt0, gnt1, busy);
        end
        do_reset();
        repeat (12) tick();
        n_checks++;
        if (done_cnt != dc) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d dones, required 0", done_cnt - dc);
        end
        run_both(2);
    endtask

    initial begin
        resetn = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        for (int i = 0; i < 32; i++) begin
            ram[i]     = 32'h0100_0000 + 32'(i);
            ref_mem[i] = 32'h0100_0000 + 32'(i);
        end
        test_reset();
        test_read_p0();
        test_write_p1();
        test_addr_hold();
        test_req_pulse();
        test_round_robin();
        test_reset_mid_wait();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single-port block RAM between two requesters: port 0 (transaction processor) and port 1 (miner/hash unit).
- Performs one read or write per grant.
- Holds the RAM address, data and write-enable stable for a fixed wait window so the RAM has time to settle.
- Returns read data with a one-cycle done pulse to the granted requester.
- Sits between the processing controllers and the RAM, replacing direct per-controller RAM drive.

Parameters:
- ADDR_W, 5, RAM address width.
- DATA_W, 32, RAM data width.
- WAIT_CYCLES, 7, cycles spent in WAIT per access. Legal range 1..15; the internal counter is 4 bits.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request; held high until done0.
- we0  in  1  port 0 access type: 1 = write, 0 = read.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- req1, we1, addr1, wdata1  in  1/1/ADDR_W/DATA_W  port 1 equivalents.
- mem_rdata  in  DATA_W  RAM read data.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_wren  out  1  RAM write enable.
- gnt0, gnt1  out  1  grant; high from ACCESS through DONE for the owning port.
- done0, done1  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  captured read data, shared by both ports.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, resetn=0):
  - State = IDLE; wait counter = 0.
  - mem_addr, mem_wdata, mem_wren, gnt*, done*, rdata, busy all 0.
  - last_grant = 1, so port 0 wins the first contention.
  - Reset asserted mid-access aborts it immediately: mem_wren drops asynchronously and no done pulse is issued.
- States:
  - IDLE -> ACCESS when req0 or req1 is high.
  - ACCESS -> WAIT unconditionally.
  - WAIT -> DONE when counter == WAIT_CYCLES-1; otherwise stay in WAIT.
  - DONE -> IDLE unconditionally.
- Arbitration, evaluated in IDLE only:
  - If only one request is high, that port is granted.
  - If both are high, the port != last_grant is granted (round-robin).
  - last_grant is updated on the IDLE->ACCESS edge.
- Capture on the IDLE->ACCESS edge:
  - The winner's addr, wdata and we are latched into mem_addr, mem_wdata and an internal we_lat.
  - Later changes on the requester inputs are ignored until the next grant.
- ACCESS and WAIT:
  - mem_addr and mem_wdata are held.
  - mem_wren = we_lat.
  - The counter starts at 0 on entry to WAIT and increments every WAIT cycle.
- DONE:
  - mem_wren = 0.
  - done<sel> = 1 for exactly one cycle; gnt<sel> stays high.
  - For reads, rdata <= mem_rdata on the WAIT->DONE edge. For writes, rdata is unchanged.
  - Counter cleared.
- Latency: request high in IDLE at cycle n gives ACCESS at n+1, WAIT at n+2..n+1+WAIT_CYCLES, and done at n+2+WAIT_CYCLES (n+9 at the default).
- Back-to-back requests:
  - A port still holding req in the IDLE cycle after DONE is re-arbitrated normally.
  - If both ports hold req continuously, grants alternate 0,1,0,1.
- Request drop:
  - Deasserting req after grant does not abort; the access completes and done still pulses.
  - A req dropped before the IDLE sample is simply not served.
- Exclusivity: gnt0 and gnt1 are never high together; done0 and done1 are never high together.
- Write contents take effect in the RAM during the wait window; rdata is meaningful only after a read's done.

Test Plan:
- Reset, then port 0 read at addr0=5 with RAM word 5 = 0xDEADBEEF -> gnt0 at n+1; mem_wren=0 throughout; done0 pulses at n+9; rdata=0xDEADBEEF; busy=0 at n+10.
- Port 1 write addr1=3, wdata1=0x12345678 -> mem_wren=1 for exactly 8 cycles (ACCESS plus 7 WAIT); mem_addr=3; done1 at n+9; a following port 0 read of addr 3 returns 0x12345678.
- req0 and req1 both high from reset and held -> grant order 0,1,0,1; each done exactly one cycle; gnt0 and gnt1 never overlap.
- Change addr0 from 5 to 9 two cycles after grant -> mem_addr stays 5 until DONE; rdata = word 5.
- Assert resetn=0 mid-WAIT of a write -> mem_wren, gnt* and busy go 0 asynchronously; no done pulse; after release, a simultaneous request pair grants port 0 first.
- req1 raised for one cycle in IDLE then dropped -> the access still completes; done1 pulses at n+9.
